// File: rtl/vector_alu.sv
// Multi-cycle element-wise vector ALU: captures two 16x16-bit source vectors,
// computes LANES elements per cycle, and writes the 256-bit result in one cycle.

module vector_alu_lane (
  input  logic [2:0]  op,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);
  always_comb begin
    y = '0;
    case (op)
      3'd0:    y = a + b;
      3'd1:    y = a - b;
      3'd2:    y = a * b;  // 16-bit context keeps only product bits [15:0]
      3'd3:    y = a & b;
      3'd4:    y = a | b;
      3'd5:    y = a ^ b;
      3'd6:    y = ($signed(a) < $signed(b)) ? a : b;
      default: y = ($signed(a) > $signed(b)) ? a : b;
    endcase
  end
endmodule

module vector_alu #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [3:0]   src0,
  input  logic [3:0]   src1,
  input  logic [3:0]   dst,
  output logic         busy,
  output logic         done,
  output logic [3:0]   rAddr0,
  output logic [3:0]   rAddr1,
  input  logic [255:0] rData0,
  input  logic [255:0] rData1,
  input  logic [3:0]   rLen0,
  input  logic [3:0]   rLen1,
  output logic         wEn,
  output logic [3:0]   wAddr,
  output logic [3:0]   wLen,
  output logic [255:0] wData
);
  localparam int NE = 16;
  localparam int EW = 16;

  typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_e;

  state_e                    state_q;
  logic [2:0]                op_q;
  logic [3:0]                src0_q, src1_q, dst_q;
  logic [NE-1:0][EW-1:0]     a_q, b_q, res_q;
  logic [4:0]                cnt_q, idx_q;
  logic                      busy_q, done_q;

  logic [4:0]                n0, n1, cnt_new;
  logic [LANES-1:0][EW-1:0]  lane_y;
  logic [LANES-1:0][3:0]     lane_e;

  // Stored length 0 encodes 16 elements; the extra top bit makes that 5'd16.
  assign n0      = {(rLen0 == 4'd0), rLen0};
  assign n1      = {(rLen1 == 4'd0), rLen1};
  assign cnt_new = (n0 < n1) ? n0 : n1;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_e[l] = idx_q[3:0] + 4'(l);
    vector_alu_lane u_lane (
      .op (op_q),
      .a  (a_q[lane_e[l]]),
      .b  (b_q[lane_e[l]]),
      .y  (lane_y[l])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      src0_q  <= '0;
      src1_q  <= '0;
      dst_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          op_q    <= op;
          src0_q  <= src0;
          src1_q  <= src1;
          dst_q   <= dst;
          a_q     <= rData0;
          b_q     <= rData1;
          cnt_q   <= cnt_new;
          idx_q   <= '0;
          res_q   <= '0;
          busy_q  <= 1'b1;
          state_q <= EXEC;
        end
        EXEC: begin
          for (int l = 0; l < LANES; l++)
            res_q[lane_e[l]] <= ({1'b0, lane_e[l]} < cnt_q) ? lane_y[l] : '0;
          idx_q <= idx_q + 5'(LANES);
          if (idx_q + 5'(LANES) >= cnt_q) begin
            done_q  <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rAddr0 = (state_q == IDLE) ? src0 : src0_q;
  assign rAddr1 = (state_q == IDLE) ? src1 : src1_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign wEn    = done_q;
  assign wAddr  = dst_q;
  assign wLen   = cnt_q[3:0];  // count 16 wraps to the 0 encoding
  assign wData  = res_q;
endmodule

// File: tb/tb_vector_alu.sv
// Bench for vector_alu: a behavioural register file plus an element-wise
// reference model drive directed and random operations.

module tb_vector_alu;
  localparam int LANES = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [3:0]   src0, src1, dst;
  logic         busy, done, wEn;
  logic [3:0]   rAddr0, rAddr1, wAddr, wLen;
  logic [255:0] rData0, rData1, wData;
  logic [3:0]   rLen0, rLen1;

  logic [255:0] rf_data [16];
  logic [3:0]   rf_len  [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rData0 = rf_data[rAddr0];
  assign rData1 = rf_data[rAddr1];
  assign rLen0  = rf_len[rAddr0];
  assign rLen1  = rf_len[rAddr1];

  vector_alu #(.LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src0(src0), .src1(src1), .dst(dst),
    .busy(busy), .done(done), .rAddr0(rAddr0), .rAddr1(rAddr1),
    .rData0(rData0), .rData1(rData1), .rLen0(rLen0), .rLen1(rLen1),
    .wEn(wEn), .wAddr(wAddr), .wLen(wLen), .wData(wData)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_op(input int o, input logic [15:0] a, input logic [15:0] b);
    int unsigned ua, ub, p;
    int sa, sb;
    ua = 32'(a); ub = 32'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    case (o)
      0: p = ua + ub;
      1: p = ua - ub;
      2: p = ua * ub;
      3: p = ua & ub;
      4: p = ua | ub;
      5: p = ua ^ ub;
      6: p = (sa < sb) ? ua : ub;
      default: p = (sa > sb) ? ua : ub;
    endcase
    return p[15:0];
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [255:0] fill(input logic [15:0] x);
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = x;
    return v;
  endfunction

  // Issues one command and observes it to completion within a bounded window.
  task automatic do_op(input int o, input int s0, input int s1, input int d,
                       input bit pulse, input bit mod, output logic [255:0] got);
    logic [255:0] exp;
    logic [3:0]   elen, gaddr, glen;
    int c0, c1, cnt, n, busy_n, done_n, wen_cyc;
    c0   = (rf_len[s0] == 4'd0) ? 16 : int'(rf_len[s0]);
    c1   = (rf_len[s1] == 4'd0) ? 16 : int'(rf_len[s1]);
    cnt  = (c0 < c1) ? c0 : c1;
    n    = (cnt + LANES - 1) / LANES;
    elen = 4'(cnt);
    exp  = '0;
    for (int i = 0; i < cnt; i++)
      exp[16*i +: 16] = ref_op(o, rf_data[s0][16*i +: 16], rf_data[s1][16*i +: 16]);

    op = 3'(o); src0 = 4'(s0); src1 = 4'(s1); dst = 4'(d); start = 1'b1;
    #1 chk("raddr0_idle", 256'(rAddr0), 256'(s0));
    @(negedge clk);
    start = 1'b0;
    busy_n = 0; done_n = 0; wen_cyc = -1; got = '0; gaddr = '0; glen = '0;
    for (int cyc = 1; cyc <= 2*n + 8; cyc++) begin
      if (busy) busy_n++;
      if (done) done_n++;
      if (wEn && wen_cyc < 0) begin
        wen_cyc = cyc; got = wData; gaddr = wAddr; glen = wLen;
      end
      if (cyc == 1) begin
        src0 = src0 + 4'd1; src1 = src1 + 4'd3;
        #1;
        chk("raddr0_held", 256'(rAddr0), 256'(s0));
        chk("raddr1_held", 256'(rAddr1), 256'(s1));
        if (pulse) begin start = 1'b1; op = 3'(o + 1); end
        if (mod) rf_data[s0] = ~rf_data[s0];
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("wen_cycle", 256'(wen_cyc), 256'(n + 1));
    chk("busy_cycles", 256'(busy_n), 256'(n + 1));
    chk("done_pulses", 256'(done_n), 256'(1));
    chk("waddr", 256'(gaddr), 256'(d));
    chk("wlen", 256'(glen), 256'(elen));
    chk("wdata", got, exp);
    rf_data[d] = exp;
    rf_len[d]  = elen;
  endtask

  initial begin
    logic [255:0] got;
    int wen_seen;
    rst_n = 1'b0; start = 1'b0; op = '0; src0 = 4'd5; src1 = 4'd9; dst = 4'd3;
    for (int r = 0; r < 16; r++) begin rf_data[r] = '0; rf_len[r] = '0; end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_wen", 256'(wEn), 256'(0));
    chk("rst_waddr", 256'(wAddr), 256'(0));
    chk("rst_wlen", 256'(wLen), 256'(0));
    chk("rst_wdata", wData, 256'(0));
    chk("rst_raddr0", 256'(rAddr0), 256'(5));
    chk("rst_raddr1", 256'(rAddr1), 256'(9));
    rst_n = 1'b1;
    @(negedge clk);

    // ADD, full length: element i = i + 2i
    for (int i = 0; i < 16; i++) begin
      rf_data[0][16*i +: 16] = 16'(i);
      rf_data[1][16*i +: 16] = 16'(2*i);
    end
    do_op(0, 0, 1, 2, 0, 0, got);
    chk("add_e5", 256'(got[16*5 +: 16]), 256'(16'd15));
    chk("add_e15", 256'(got[16*15 +: 16]), 256'(16'd45));

    // SUB / MUL wrap
    rf_data[3] = fill(16'h0000); rf_data[4] = fill(16'h0001);
    do_op(1, 3, 4, 10, 0, 0, got);
    chk("sub_wrap", 256'(got[15:0]), 256'(16'hFFFF));
    rf_data[5] = fill(16'h00FF); rf_data[6] = fill(16'h0003);
    do_op(2, 5, 6, 11, 0, 0, got);
    chk("mul_low", 256'(got[15:0]), 256'(16'h02FD));
    rf_data[7] = fill(16'h0100);
    do_op(2, 7, 7, 12, 0, 0, got);
    chk("mul_zero", got, 256'(0));

    // Length mismatch 3 vs 5
    rf_data[8] = rnd256(); rf_len[8] = 4'd3;
    rf_data[9] = rnd256(); rf_len[9] = 4'd5;
    do_op(5, 8, 9, 13, 0, 0, got);
    chk("len_tail_zero", 256'(got[255:48]), 256'(0));

    // Signed MIN/MAX
    for (int i = 0; i < 16; i++) begin
      rf_data[8][16*i +: 16] = (i % 2 == 0) ? 16'h8000 : 16'hFFFF;
      rf_data[9][16*i +: 16] = (i % 2 == 0) ? 16'h0001 : 16'h0000;
    end
    rf_len[8] = 4'd0; rf_len[9] = 4'd0;
    do_op(6, 8, 9, 14, 0, 0, got);
    chk("min_neg", 256'(got[15:0]), 256'(16'h8000));
    chk("min_m1", 256'(got[31:16]), 256'(16'hFFFF));
    do_op(7, 8, 9, 14, 0, 0, got);
    chk("max_pos", 256'(got[15:0]), 256'(16'h0001));

    // Control: start mid-EXEC ignored; dst = src0; source modified during EXEC
    do_op(0, 0, 1, 3, 1, 0, got);
    do_op(4, 0, 1, 0, 0, 1, got);

    // Reset mid-EXEC
    rf_len[0] = 4'd0; rf_len[1] = 4'd0;
    op = 3'd0; src0 = 4'd0; src1 = 4'd1; dst = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 256'(busy), 256'(0));
    chk("abort_wen", 256'(wEn), 256'(0));
    wen_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (wEn) wen_seen++;
      if (c == 2) rst_n = 1'b1;
    end
    chk("abort_no_write", 256'(wen_seen), 256'(0));
    do_op(1, 0, 1, 15, 0, 0, got);

    // Random operations
    for (int t = 0; t < 24; t++) begin
      int s0r, s1r;
      s0r = int'($urandom_range(0, 15));
      s1r = int'($urandom_range(0, 15));
      rf_data[s0r] = rnd256(); rf_len[s0r] = 4'($urandom_range(0, 15));
      rf_data[s1r] = rnd256(); rf_len[s1r] = 4'($urandom_range(0, 15));
      do_op(int'($urandom_range(0, 7)), s0r, s1r, int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
